// File: rtl/alu_pkg.sv
// Shared opcode constants and control-state encoding for the extended J1 ALU.
// Base ops occupy 0_xxxx; the iterative multiply/divide live in 1_xxxx.
package alu_pkg;

   localparam logic [2:0] CLS_JUMP  = 3'b000;
   localparam logic [2:0] CLS_CJUMP = 3'b001;
   localparam logic [2:0] CLS_CALL  = 3'b010;
   localparam logic [2:0] CLS_ALU   = 3'b011;

   localparam logic [4:0] OP_T       = 5'b0_0000;
   localparam logic [4:0] OP_N       = 5'b0_0001;
   localparam logic [4:0] OP_ADD     = 5'b0_0010;
   localparam logic [4:0] OP_AND     = 5'b0_0011;
   localparam logic [4:0] OP_OR      = 5'b0_0100;
   localparam logic [4:0] OP_XOR     = 5'b0_0101;
   localparam logic [4:0] OP_INV     = 5'b0_0110;
   localparam logic [4:0] OP_EQ      = 5'b0_0111;
   localparam logic [4:0] OP_SLT     = 5'b0_1000;
   localparam logic [4:0] OP_ASR     = 5'b0_1001;
   localparam logic [4:0] OP_LSL     = 5'b0_1010;
   localparam logic [4:0] OP_R       = 5'b0_1011;
   localparam logic [4:0] OP_SUB     = 5'b0_1100;
   localparam logic [4:0] OP_IO      = 5'b0_1101;
   localparam logic [4:0] OP_DEPTH   = 5'b0_1110;
   localparam logic [4:0] OP_ULT     = 5'b0_1111;
   localparam logic [4:0] OP_UMUL    = 5'b1_0000;
   localparam logic [4:0] OP_UDIVMOD = 5'b1_0001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } alu_state_t;

   function automatic logic is_iter_op(input logic [4:0] op);
      return (op == OP_UMUL) || (op == OP_UDIVMOD);
   endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath: shift-add multiply and restoring divide, one step per cycle.
// acc holds the product high half / remainder, quo the product low half / quotient.
module alu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             resetq,
   input  logic             load,
   input  logic             run,
   input  logic             is_div,
   input  logic [WIDTH-1:0] n,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] quo,
   output logic             last
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] acc_r, quo_r, opd_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   shl_s;
   logic             ge_s;
   logic [WIDTH-1:0] diff_s;
   logic [WIDTH-1:0] acc_nxt_s, quo_nxt_s;

   // One multiply or divide step computed from the current partial state.
   always_comb begin
      sum_s     = {1'b0, acc_r} + {1'b0, opd_r};
      shl_s     = {acc_r, quo_r[WIDTH-1]};
      ge_s      = (shl_s >= {1'b0, opd_r});
      diff_s    = shl_s[WIDTH-1:0] - opd_r;
      acc_nxt_s = acc_r;
      quo_nxt_s = quo_r;
      if (is_div) begin
         if (ge_s) begin
            acc_nxt_s = diff_s;
            quo_nxt_s = {quo_r[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt_s = shl_s[WIDTH-1:0];
            quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (quo_r[0]) begin
            acc_nxt_s = sum_s[WIDTH:1];
            quo_nxt_s = {sum_s[0], quo_r[WIDTH-1:1]};
         end else begin
            acc_nxt_s = {1'b0, acc_r[WIDTH-1:1]};
            quo_nxt_s = {acc_r[0], quo_r[WIDTH-1:1]};
         end
      end
   end

   // Operand latch on load, then one iteration per run cycle.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         acc_r <= {WIDTH{1'b0}};
         quo_r <= {WIDTH{1'b0}};
         opd_r <= {WIDTH{1'b0}};
         cnt_r <= {CW{1'b0}};
      end else if (load) begin
         acc_r <= {WIDTH{1'b0}};
         quo_r <= is_div ? n : t;
         opd_r <= is_div ? t : n;
         cnt_r <= {CW{1'b0}};
      end else if (run) begin
         acc_r <= acc_nxt_s;
         quo_r <= quo_nxt_s;
         cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         acc_r <= acc_r;
         quo_r <= quo_r;
         cnt_r <= cnt_r;
      end
   end

   assign acc  = acc_r;
   assign quo  = quo_r;
   assign last = (cnt_r == CW'(WIDTH-1));

endmodule

// File: rtl/alu_ext.sv
// J1-compatible ALU with WIDTH-bit datapath plus iterative UMUL/UDIVMOD.
// Base ops are combinational; multiply/divide stall the CPU for WIDTH cycles.
module alu_ext
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SPW   = 4
) (
   input  logic             clk,
   input  logic             resetq,
   input  logic [15:0]      instruction,
   input  logic [12:0]      pc,
   input  logic [WIDTH-1:0] topOfDataStack,
   input  logic [WIDTH-1:0] secondItemOfDataStack,
   input  logic [WIDTH-1:0] topOfReturnStack,
   input  logic [WIDTH-1:0] io_din,
   input  logic [SPW-1:0]   dataStackPointer,
   input  logic             start,
   output logic [WIDTH-1:0] topOfDataStackNew,
   output logic [WIDTH-1:0] secondItemNew,
   output logic             writeSecond,
   output logic             busy,
   output logic             done
);

   alu_state_t       state_r, state_nxt_s;
   logic [4:0]       op_s;
   logic             ext_go_s;
   logic [WIDTH:0]   minus_s;
   logic [WIDTH-1:0] base_s;
   logic             load_s, run_s, mode_div_s, iter_last_s;
   logic [WIDTH-1:0] acc_s, quo_s;
   logic             unused_ok_s;

   assign op_s        = instruction[12:8];
   assign ext_go_s    = !pc[12] && (instruction[15:13] == CLS_ALU) && is_iter_op(op_s);
   assign unused_ok_s = ^{instruction[7:0], pc[11:0]};

   // Single-cycle J1 result; minus_s carries N-T with a borrow bit for the compares.
   always_comb begin
      minus_s = {1'b1, ~topOfDataStack} + {1'b0, secondItemOfDataStack} + {{WIDTH{1'b0}}, 1'b1};
      base_s  = topOfDataStack;
      if (pc[12]) begin
         base_s = WIDTH'(instruction);
      end else if (instruction[15]) begin
         base_s = WIDTH'(instruction[14:0]);
      end else begin
         case (instruction[15:13])
            CLS_JUMP, CLS_CALL: base_s = topOfDataStack;
            CLS_CJUMP:          base_s = secondItemOfDataStack;
            CLS_ALU: begin
               case (op_s)
                  OP_T:     base_s = topOfDataStack;
                  OP_N:     base_s = secondItemOfDataStack;
                  OP_ADD:   base_s = topOfDataStack + secondItemOfDataStack;
                  OP_AND:   base_s = topOfDataStack & secondItemOfDataStack;
                  OP_OR:    base_s = topOfDataStack | secondItemOfDataStack;
                  OP_XOR:   base_s = topOfDataStack ^ secondItemOfDataStack;
                  OP_INV:   base_s = ~topOfDataStack;
                  OP_EQ:    base_s = {WIDTH{minus_s[WIDTH-1:0] == {WIDTH{1'b0}}}};
                  OP_SLT:   base_s = {WIDTH{(secondItemOfDataStack[WIDTH-1] ^ topOfDataStack[WIDTH-1])
                                            ? secondItemOfDataStack[WIDTH-1] : minus_s[WIDTH]}};
                  OP_ASR:   base_s = {topOfDataStack[WIDTH-1], topOfDataStack[WIDTH-1:1]};
                  OP_LSL:   base_s = {topOfDataStack[WIDTH-2:0], 1'b0};
                  OP_R:     base_s = topOfReturnStack;
                  OP_SUB:   base_s = minus_s[WIDTH-1:0];
                  OP_IO:    base_s = io_din;
                  OP_DEPTH: base_s = WIDTH'(dataStackPointer);
                  OP_ULT:   base_s = {WIDTH{minus_s[WIDTH]}};
                  default:  base_s = topOfDataStack;
               endcase
            end
            default: base_s = topOfDataStack;
         endcase
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state and outputs; start is only honoured in IDLE.
   always_comb begin
      state_nxt_s       = state_r;
      busy              = 1'b0;
      done              = 1'b0;
      writeSecond       = 1'b0;
      topOfDataStackNew = base_s;
      secondItemNew     = acc_s;
      load_s            = 1'b0;
      run_s             = 1'b0;
      mode_div_s        = (op_s == OP_UDIVMOD);
      case (state_r)
         ST_IDLE: begin
            if (start && ext_go_s) begin
               load_s      = 1'b1;
               state_nxt_s = (op_s == OP_UDIVMOD) ? ST_DIV : ST_MUL;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_MUL, ST_DIV: begin
            busy              = 1'b1;
            run_s             = 1'b1;
            mode_div_s        = (state_r == ST_DIV);
            topOfDataStackNew = topOfDataStack;
            if (iter_last_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_DONE: begin
            done              = 1'b1;
            writeSecond       = 1'b1;
            topOfDataStackNew = quo_s;
            secondItemNew     = acc_s;
            state_nxt_s       = ST_IDLE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   alu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .resetq (resetq),
      .load   (load_s),
      .run    (run_s),
      .is_div (mode_div_s),
      .n      (secondItemOfDataStack),
      .t      (topOfDataStack),
      .acc    (acc_s),
      .quo    (quo_s),
      .last   (iter_last_s)
   );

endmodule

// File: tb/tb_alu_ext.sv
// Directed-vector bench for alu_ext at WIDTH=16 and WIDTH=32.
module tb_alu_ext;

   logic        clk;
   logic        resetq, start, wsec, busy, done;
   logic [15:0] instruction, tos, nos, rtos, iod, t_new, n_new;
   logic [12:0] pc;
   logic [3:0]  dsp;

   logic        w_resetq, w_start, w_wsec, w_busy, w_done;
   logic [15:0] w_instruction;
   logic [12:0] w_pc;
   logic [31:0] w_tos, w_nos, w_rtos, w_iod, w_t_new, w_n_new;
   logic [3:0]  w_dsp;

   int vectors    = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [15:0] ins;
      logic [15:0] n;
      logic [15:0] t;
      logic [15:0] exp;
   } vec_t;

   alu_ext #(.WIDTH(16), .SPW(4)) dut16 (
      .clk(clk), .resetq(resetq), .instruction(instruction), .pc(pc),
      .topOfDataStack(tos), .secondItemOfDataStack(nos), .topOfReturnStack(rtos), .io_din(iod),
      .dataStackPointer(dsp), .start(start),
      .topOfDataStackNew(t_new), .secondItemNew(n_new), .writeSecond(wsec), .busy(busy), .done(done)
   );

   alu_ext #(.WIDTH(32), .SPW(4)) dut32 (
      .clk(clk), .resetq(w_resetq), .instruction(w_instruction), .pc(w_pc),
      .topOfDataStack(w_tos), .secondItemOfDataStack(w_nos), .topOfReturnStack(w_rtos), .io_din(w_iod),
      .dataStackPointer(w_dsp), .start(w_start),
      .topOfDataStackNew(w_t_new), .secondItemNew(w_n_new), .writeSecond(w_wsec), .busy(w_busy), .done(w_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      resetq = 1'b0; w_resetq = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
      vectors++; if (wsec !== 1'b0) begin miscompares++; $display("FAIL reset_wsec: got %b want 0", wsec); end
      resetq = 1'b1; w_resetq = 1'b1;
      @(negedge clk); #1;
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_release_done: got %b want 0", done); end
   endtask

   task automatic test_base_ops();
      vec_t tab [16];
      tab = '{
         '{16'h6200, 16'h0005, 16'h0007, 16'h000C},
         '{16'h6800, 16'h8000, 16'h0001, 16'hFFFF},
         '{16'h6F00, 16'h8000, 16'h0001, 16'h0000},
         '{16'h6F00, 16'h0001, 16'h8000, 16'hFFFF},
         '{16'h6C00, 16'h0005, 16'h0007, 16'hFFFE},
         '{16'h6700, 16'h1234, 16'h1234, 16'hFFFF},
         '{16'h6700, 16'h1234, 16'h1235, 16'h0000},
         '{16'h6900, 16'h0000, 16'h8002, 16'hC001},
         '{16'h6A00, 16'h0000, 16'h8001, 16'h0002},
         '{16'h6600, 16'h0000, 16'h00F0, 16'hFF0F},
         '{16'h8123, 16'h0000, 16'h5555, 16'h0123},
         '{16'h2000, 16'hBEEF, 16'h1111, 16'hBEEF},
         '{16'h0040, 16'hBEEF, 16'h1111, 16'h1111},
         '{16'h6B00, 16'h0000, 16'h0000, 16'hCAFE},
         '{16'h6D00, 16'h0000, 16'h0000, 16'h0F0F},
         '{16'h6E00, 16'h0000, 16'h0000, 16'h000A}
      };
      rtos = 16'hCAFE; iod = 16'h0F0F; dsp = 4'hA; pc = 13'h0000; start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         instruction = tab[i].ins; nos = tab[i].n; tos = tab[i].t;
         #1;
         vectors++;
         if (t_new !== tab[i].exp) begin
            miscompares++; $display("FAIL base_op[%0d] ins=%h: got %h want %h", i, tab[i].ins, t_new, tab[i].exp);
         end
         vectors++;
         if (busy !== 1'b0 || wsec !== 1'b0) begin
            miscompares++; $display("FAIL base_flags[%0d]: got busy=%b wsec=%b want 0 0", i, busy, wsec);
         end
      end
      @(negedge clk);
      pc = 13'h1000; instruction = 16'h6200; tos = 16'h0007; nos = 16'h0005;
      #1;
      vectors++; if (t_new !== 16'h6200) begin miscompares++; $display("FAIL pc_literal: got %h want 6200", t_new); end
      pc = 13'h0000;
   endtask

   task automatic test_ignored_start();
      @(negedge clk);
      instruction = 16'h7500; tos = 16'h1357; nos = 16'h2468; start = 1'b1;
      #1;
      vectors++; if (t_new !== 16'h1357) begin miscompares++; $display("FAIL ext_other: got %h want 1357", t_new); end
      @(negedge clk);
      start = 1'b0; #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++; $display("FAIL ext_other_nostall: got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic run_ext16(input logic [15:0] ins, input logic [15:0] nv, input logic [15:0] tv,
                            input int pulse_at, output int done_cyc, output int done_cnt,
                            output int busy_first, output int busy_cnt, output int hold_bad,
                            output logic [15:0] t_res, output logic [15:0] n_res, output logic ws_res);
      done_cyc = -1; done_cnt = 0; busy_first = -1; busy_cnt = 0; hold_bad = 0;
      t_res = 16'h0000; n_res = 16'h0000; ws_res = 1'b0;
      @(negedge clk);
      pc = 13'h0000; instruction = ins; nos = nv; tos = tv; start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = (c == pulse_at);
         tos = tv ^ 16'h5A5A ^ c[15:0];
         nos = ~nv;
         #1;
         if (busy === 1'b1) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = c;
            if (wsec !== 1'b0 || t_new !== tos) hold_bad++;
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) begin done_cyc = c; t_res = t_new; n_res = n_new; ws_res = wsec; end
         end
      end
      start = 1'b0;
   endtask

   task automatic test_ext_op(input string name, input logic [15:0] ins, input logic [15:0] nv,
                              input logic [15:0] tv, input int pulse_at,
                              input logic [15:0] exp_t, input logic [15:0] exp_n);
      int dc, dn, bf, bc, hb;
      logic [15:0] tr, nr;
      logic wr;
      run_ext16(ins, nv, tv, pulse_at, dc, dn, bf, bc, hb, tr, nr, wr);
      vectors++; if (dc !== 17) begin miscompares++; $display("FAIL %s_done_cycle: got %0d want 17", name, dc); end
      vectors++; if (dn !== 1) begin miscompares++; $display("FAIL %s_done_count: got %0d want 1", name, dn); end
      vectors++; if (bf !== 1 || bc !== 16) begin miscompares++; $display("FAIL %s_busy: got first=%0d count=%0d want 1 16", name, bf, bc); end
      vectors++; if (hb !== 0) begin miscompares++; $display("FAIL %s_busy_hold: got %0d bad cycles want 0", name, hb); end
      vectors++; if (tr !== exp_t) begin miscompares++; $display("FAIL %s_t: got %h want %h", name, tr, exp_t); end
      vectors++; if (nr !== exp_n) begin miscompares++; $display("FAIL %s_n: got %h want %h", name, nr, exp_n); end
      vectors++; if (wr !== 1'b1) begin miscompares++; $display("FAIL %s_wsec: got %b want 1", name, wr); end
   endtask

   task automatic test_umul();
      test_ext_op("umul", 16'h7000, 16'h1234, 16'h0100, 0, 16'h3400, 16'h0012);
   endtask

   task automatic test_udivmod();
      test_ext_op("udivmod", 16'h7100, 16'd100, 16'd7, 0, 16'd14, 16'd2);
      test_ext_op("div_zero", 16'h7100, 16'h00FF, 16'h0000, 0, 16'hFFFF, 16'h00FF);
   endtask

   task automatic test_back_to_back();
      test_ext_op("restart_ignored", 16'h7000, 16'h1234, 16'h0100, 5, 16'h3400, 16'h0012);
   endtask

   task automatic test_reset_abort();
      int dn;
      dn = 0;
      @(negedge clk);
      pc = 13'h0000; instruction = 16'h7100; nos = 16'd100; tos = 16'd7; start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy_before: got %b want 1", busy); end
      resetq = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
      vectors++; if (done !== 1'b0 || wsec !== 1'b0) begin miscompares++; $display("FAIL abort_outputs: got done=%b wsec=%b want 0 0", done, wsec); end
      @(negedge clk);
      resetq = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk); #1;
         if (done === 1'b1 || wsec === 1'b1 || busy === 1'b1) dn++;
      end
      vectors++; if (dn !== 0) begin miscompares++; $display("FAIL abort_after_release: got %0d active cycles want 0", dn); end
   endtask

   task automatic test_wide_umul();
      int dc, bc;
      logic [31:0] tr, nr;
      dc = -1; bc = 0; tr = 32'h0; nr = 32'h0;
      @(negedge clk);
      w_pc = 13'h0000; w_instruction = 16'h7000; w_nos = 32'hFFFFFFFF; w_tos = 32'h00000002; w_start = 1'b1;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         w_start = 1'b0; w_tos = 32'h13579BDF; w_nos = 32'h2468ACE0;
         #1;
         if (w_busy === 1'b1) bc++;
         if (w_done === 1'b1 && dc < 0) begin dc = c; tr = w_t_new; nr = w_n_new; end
      end
      vectors++; if (dc !== 33) begin miscompares++; $display("FAIL wide_done_cycle: got %0d want 33", dc); end
      vectors++; if (bc !== 32) begin miscompares++; $display("FAIL wide_busy_count: got %0d want 32", bc); end
      vectors++; if (tr !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL wide_t: got %h want fffffffe", tr); end
      vectors++; if (nr !== 32'h00000001) begin miscompares++; $display("FAIL wide_n: got %h want 00000001", nr); end
   endtask

   initial begin
      instruction = 16'h0000; pc = 13'h0000; tos = 16'h0000; nos = 16'h0000;
      rtos = 16'h0000; iod = 16'h0000; dsp = 4'h0; start = 1'b0; resetq = 1'b0;
      w_instruction = 16'h0000; w_pc = 13'h0000; w_tos = 32'h0; w_nos = 32'h0;
      w_rtos = 32'h0; w_iod = 32'h0; w_dsp = 4'h0; w_start = 1'b0; w_resetq = 1'b0;
      test_reset();
      test_base_ops();
      test_ignored_start();
      test_umul();
      test_udivmod();
      test_back_to_back();
      test_reset_abort();
      test_wide_umul();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_ext.md
ALU_EXT -- requirements
Module: alu_ext

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits (minimum 16, even).
REQ-002 SHALL have parameter SPW, default 4, data-stack-pointer width.
REQ-003 SHALL have port clk  in  1  single system clock; all state on rising edge.
REQ-004 SHALL have port resetq  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port instruction  in  16  current instruction word.
REQ-006 SHALL have port pc  in  13  program counter; pc[12]=1 forces literal.
REQ-007 SHALL have ports topOfDataStack, secondItemOfDataStack, topOfReturnStack, io_din  in  WIDTH  T, N, R, I/O read data.
REQ-008 SHALL have port dataStackPointer  in  SPW  current depth.
REQ-009 SHALL have port start  in  1  CPU issues the current instruction this cycle.
REQ-010 SHALL have port topOfDataStackNew  out  WIDTH  next T.
REQ-011 SHALL have port secondItemNew  out  WIDTH  next N, valid only when writeSecond=1.
REQ-012 SHALL have port writeSecond  out  1  N must be overwritten with secondItemNew.
REQ-013 SHALL have ports busy  out  1 (CPU stall) and done  out  1 (one-cycle result pulse).

Function
REQ-014 SHALL compute literal/jump/call/conditional-jump T exactly as the 16-bit J1 ALU, zero-extending literals (pc[12]: full instruction; instruction[15]: bits 14:0) to WIDTH.
REQ-015 SHALL, for ALU class (instruction[15:13]=011) with instruction[12]=0, execute the 16 base ops (T, N, +, and, or, xor, invert, =, signed <, asr 1, lsl 1, R, N-T, io_din, depth, unsigned <) combinationally at WIDTH bits, busy=0, writeSecond=0.
REQ-016 SHALL use WIDTH+1-bit N-T with carry for = and unsigned <; signed < compares bit WIDTH-1; depth zero-extended.
REQ-017 SHALL, for instruction[12]=1, decode op 1_0000 UMUL (T<=low WIDTH of N*T, N<=high WIDTH) and 1_0001 UDIVMOD (T<=N/T, N<=N mod T); other 1_xxxx codes SHALL return T, no stall.
REQ-018 SHALL implement FSM IDLE -> MUL|DIV -> DONE -> IDLE.
REQ-019 SHALL leave IDLE only when start=1 and a UMUL/UDIVMOD is decoded; operands latched that edge (cycle 0).
REQ-020 SHALL hold busy=1 for cycles 1..WIDTH, one shift-add/shift-subtract iteration per cycle.
REQ-021 SHALL in cycle WIDTH+1 (DONE) drive done=1, busy=0, writeSecond=1, results on topOfDataStackNew/secondItemNew, then return to IDLE.
REQ-022 SHALL, while busy=1, drive topOfDataStackNew=topOfDataStack, writeSecond=0, and ignore start and all data inputs.
REQ-023 SHALL yield quotient all-ones and remainder=N for T=0, same latency, no error flag.
REQ-024 SHALL accept a new start in the DONE cycle only on the following cycle (no back-to-back overlap).
REQ-025 SHALL ignore start when the decoded op is not UMUL/UDIVMOD (no state change).

Reset
REQ-026 SHALL on resetq=0 immediately force IDLE, busy=0, done=0, writeSecond=0, internal accumulators/quotient regs 0, aborting any operation.
REQ-027 SHALL release reset without emitting done or stale results.

Structure
REQ-028 SHALL place op-code constants (base and extended) and the FSM state enum in shared package alu_pkg.
REQ-029 SHALL isolate the iterative datapath (shift-add multiply, restoring divide, WIDTH-cycle counter) in sub-module alu_iter; alu_ext keeps decode, combinational ops, FSM.

Verification
REQ-030 SHALL cover: WIDTH=16, op +, T=0x0007, N=0x0005 -> topOfDataStackNew=0x000C same cycle, busy=0.
REQ-031 SHALL cover: signed <, N=0x8000, T=0x0001 -> 0xFFFF; unsigned < same operands -> 0x0000.
REQ-032 SHALL cover: UMUL N=0x1234, T=0x0100, start -> busy cycles 1..16, done cycle 17 with T=0x3400, N=0x0012.
REQ-033 SHALL cover: UDIVMOD N=100, T=7 -> done cycle 17, T=14, N=2; N=0x00FF, T=0 -> T=0xFFFF, N=0x00FF.
REQ-034 SHALL cover: start pulsed at cycle 5 of a UMUL -> ignored, single done at cycle 17, original result.
REQ-035 SHALL cover: resetq low at cycle 8 of UDIVMOD -> busy=0 immediately, no done after release; WIDTH=32 UMUL 0xFFFFFFFF*2 -> T=0xFFFFFFFE, N=1, done cycle 33.
